// File: rtl/bnn_stream_feeder.sv
// bnn_stream_feeder: host-loaded preload storage for a binarized neural
// network accelerator. It streams image bits, conv weights and FC weights
// on accelerator request, and captures the predicted class for the host.
module bnn_stream_feeder (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [9:0] cfg_addr,
  input  logic [9:0] cfg_wdata,
  input  logic       run,
  output logic       busy,
  output logic       start,
  output logic       image_bit,
  input  logic       weight_en_0,
  input  logic       weight_en_1,
  output logic       weight_conv_bit,
  input  logic       fc_ivalid,
  output logic [9:0] weight_fc,
  input  logic       done,
  input  logic [3:0] classes_b,
  output logic [3:0] result,
  output logic       result_valid,
  input  logic       result_ack
);

  localparam logic [9:0] IMG_N    = 10'd784;
  localparam logic [9:0] CONV0_N  = 10'd18;
  localparam logic [4:0] CONV0_L0 = 5'd9;
  localparam logic [4:0] CONV0_L1 = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t state;

  // Preload storage: never reset, so the host loads it once per model.
  logic [7:0]  img_mem   [0:783];
  logic [17:0] conv0_mem;
  logic        conv1_mem [0:1023];
  logic [9:0]  fc_mem    [0:1023];

  // Stream read pointers.
  logic [9:0] img_ptr;
  logic [4:0] conv_cnt;
  logic [9:0] conv1_ptr;
  logic [9:0] fc_ptr;

  logic cfg_ok;
  assign cfg_ok = !rst && cfg_we && (state == S_IDLE);

  // Host writes into preload storage; out-of-range image/conv0 writes are dropped.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      case (cfg_sel)
        2'd0: if (cfg_addr < IMG_N) img_mem[cfg_addr] <= cfg_wdata[7:0];
        2'd1: if (cfg_addr < CONV0_N) conv0_mem[cfg_addr[4:0]] <= cfg_wdata[0];
        2'd2: conv1_mem[cfg_addr] <= cfg_wdata[0];
        default: fc_mem[cfg_addr] <= cfg_wdata;
      endcase
    end
  end

  // Control FSM plus all registered stream outputs (one-cycle latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      start           <= 1'b0;
      busy            <= 1'b0;
      image_bit       <= 1'b0;
      weight_conv_bit <= 1'b0;
      weight_fc       <= 10'd0;
      result          <= 4'd0;
      result_valid    <= 1'b0;
      img_ptr         <= 10'd0;
      conv_cnt        <= 5'd0;
      conv1_ptr       <= 10'd0;
      fc_ptr          <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state     <= S_STREAM;
            start     <= 1'b1;
            busy      <= 1'b1;
            img_ptr   <= 10'd0;
            conv_cnt  <= 5'd0;
            conv1_ptr <= 10'd0;
            fc_ptr    <= 10'd0;
          end
        end

        S_STREAM: begin
          // Pixels are binarized by their MSB and sent inverted; the stream
          // parks at 0 once the whole image has gone out.
          if (img_ptr < IMG_N) begin
            image_bit <= ~img_mem[img_ptr][7];
            img_ptr   <= img_ptr + 10'd1;
          end else begin
            image_bit <= 1'b0;
          end

          // conv0 holds layer-0 bits [0..8] then layer-1 bits [9..17];
          // once a layer's share is used up, requests fall through to conv1.
          if (weight_en_0 && (conv_cnt < CONV0_L0)) begin
            weight_conv_bit <= conv0_mem[conv_cnt];
            conv_cnt        <= conv_cnt + 5'd1;
          end else if (weight_en_1 && (conv_cnt < CONV0_L1)) begin
            weight_conv_bit <= conv0_mem[conv_cnt];
            conv_cnt        <= conv_cnt + 5'd1;
          end else if (weight_en_0 || weight_en_1) begin
            weight_conv_bit <= conv1_mem[conv1_ptr];
            conv1_ptr       <= conv1_ptr + 10'd1;
          end

          if (fc_ivalid) begin
            weight_fc <= fc_mem[fc_ptr];
            fc_ptr    <= fc_ptr + 10'd1;
          end

          if (done) begin
            state        <= S_WAIT_ACK;
            start        <= 1'b0;
            result       <= classes_b;
            result_valid <= 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (result_ack) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_stream_feeder.sv
// Testbench for bnn_stream_feeder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the feeder.
module tb_bnn_stream_feeder;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [9:0] cfg_addr;
  logic [9:0] cfg_wdata;
  logic       run;
  logic       busy;
  logic       start;
  logic       image_bit;
  logic       weight_en_0;
  logic       weight_en_1;
  logic       weight_conv_bit;
  logic       fc_ivalid;
  logic [9:0] weight_fc;
  logic       done;
  logic [3:0] classes_b;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ack;

  bnn_stream_feeder dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .run(run),
    .busy(busy), .start(start), .image_bit(image_bit),
    .weight_en_0(weight_en_0), .weight_en_1(weight_en_1),
    .weight_conv_bit(weight_conv_bit), .fc_ivalid(fc_ivalid),
    .weight_fc(weight_fc), .done(done), .classes_b(classes_b),
    .result(result), .result_valid(result_valid), .result_ack(result_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: storage contents, mode and stream positions.
  logic [7:0] m_pix   [784];
  logic       m_conv0 [18];
  logic       m_conv1 [1024];
  logic [9:0] m_fc    [1024];
  int         m_mode = 0;  // 0 idle, 1 streaming, 2 waiting for ack
  int         m_p = 0, m_c = 0, m_q = 0, m_f = 0;
  logic       m_busy = 0, m_start = 0, m_img = 0, m_cbit = 0, m_rv = 0;
  logic [9:0] m_wfc = 0;
  logic [3:0] m_res = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int a;
    a = int'(cfg_addr);
    if (rst) begin
      m_mode = 0; m_busy = 0; m_start = 0; m_img = 0; m_cbit = 0;
      m_wfc = 0; m_res = 0; m_rv = 0; m_p = 0; m_c = 0; m_q = 0; m_f = 0;
    end else if (m_mode == 0) begin
      if (cfg_we) begin
        case (cfg_sel)
          2'd0: if (a < 784) m_pix[a] = cfg_wdata[7:0];
          2'd1: if (a < 18) m_conv0[a] = cfg_wdata[0];
          2'd2: m_conv1[a] = cfg_wdata[0];
          default: m_fc[a] = cfg_wdata;
        endcase
      end
      if (run) begin
        m_mode = 1; m_start = 1; m_busy = 1;
        m_p = 0; m_c = 0; m_q = 0; m_f = 0;
      end
    end else if (m_mode == 1) begin
      if (m_p < 784) begin
        m_img = ~m_pix[m_p][7];
        m_p++;
      end else begin
        m_img = 0;
      end
      if ((weight_en_0 && m_c < 9) || (!weight_en_0 && weight_en_1 && m_c < 18) ||
          (weight_en_0 && weight_en_1 && m_c < 18)) begin
        m_cbit = m_conv0[m_c];
        m_c++;
      end else if (weight_en_0 || weight_en_1) begin
        m_cbit = m_conv1[m_q];
        m_q = (m_q + 1) % 1024;
      end
      if (fc_ivalid) begin
        m_wfc = m_fc[m_f];
        m_f = (m_f + 1) % 1024;
      end
      if (done) begin
        m_res = classes_b; m_rv = 1; m_start = 0; m_mode = 2;
      end
    end else begin
      if (result_ack) begin
        m_rv = 0; m_busy = 0; m_mode = 0;
      end
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) model_step();

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("start", 32'(start), 32'(m_start));
      chk("image_bit", 32'(image_bit), 32'(m_img));
      chk("weight_conv_bit", 32'(weight_conv_bit), 32'(m_cbit));
      chk("weight_fc", 32'(weight_fc), 32'(m_wfc));
      chk("result", 32'(result), 32'(m_res));
      chk("result_valid", 32'(result_valid), 32'(m_rv));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_wdata = 0; run = 0;
    weight_en_0 = 0; weight_en_1 = 0; fc_ivalid = 0; done = 0;
    classes_b = 0; result_ack = 0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [9:0] addr, input logic [9:0] data);
    cfg_we = 1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 0;
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++) begin
      weight_en_0 = ($urandom_range(3, 0) != 0);
      weight_en_1 = ($urandom_range(3, 0) != 0);
      fc_ivalid   = ($urandom_range(2, 0) != 0);
      cfg_we      = $urandom_range(1, 0);
      cfg_sel     = 2'($urandom_range(3, 0));
      cfg_addr    = 10'($urandom_range(1023, 0));
      cfg_wdata   = 10'($urandom_range(1023, 0));
      run         = $urandom_range(1, 0);
      result_ack  = $urandom_range(1, 0);
      step();
    end
    clear_in();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_image_bit"}, 32'(image_bit), 32'd0);
    chk({tag, "_conv_bit"}, 32'(weight_conv_bit), 32'd0);
    chk({tag, "_weight_fc"}, 32'(weight_fc), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    clear_in();
    rst = 1;
    step();
    cmp_en = 1;
    step();
    chk_all_zero("reset");
    rst = 0;

    // Preload every store so the whole stream is defined.
    for (int i = 0; i < 784; i++)
      cfg_write(2'd0, 10'(i), (i == 0) ? 10'h080 : (i == 1) ? 10'h07F : 10'($urandom_range(1023, 0)));
    for (int i = 0; i < 18; i++)
      cfg_write(2'd1, 10'(i), (i % 2 == 0) ? 10'd1 : 10'd0);
    for (int i = 0; i < 1024; i++)
      cfg_write(2'd2, 10'(i), (i < 2) ? 10'd1 : 10'($urandom_range(1, 0)));
    for (int i = 0; i < 1024; i++)
      cfg_write(2'd3, 10'(i), (i == 0) ? 10'h3FF : (i == 1) ? 10'h001 : (i == 2) ? 10'h155 :
                10'($urandom_range(1023, 0)));
    cfg_write(2'd0, 10'd900, 10'h0FF);
    cfg_write(2'd1, 10'd25, 10'd1);

    // Start an inference: first two pixels give 0 then 1.
    run = 1; step(); run = 0;
    chk("run_start", 32'(start), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    step();
    chk("pixel0", 32'(image_bit), 32'd0);
    step();
    chk("pixel1", 32'(image_bit), 32'd1);
    chk("stream_start", 32'(start), 32'd1);

    // Layer-0 takes conv0[0..8] then falls through to conv1[0].
    weight_en_0 = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("conv_l0", 32'(weight_conv_bit), (k < 9) ? 32'((k % 2) == 0) : 32'd1);
    end
    weight_en_0 = 0;
    // Layer-1 takes conv0[9..17] then conv1 continues at q=1.
    weight_en_1 = 1;
    for (int k = 9; k < 18; k++) begin
      step();
      chk("conv_l1", 32'(weight_conv_bit), 32'((k % 2) == 0));
    end
    step();
    chk("conv1_q1", 32'(weight_conv_bit), 32'd1);
    weight_en_1 = 0;
    step();
    chk("conv_hold", 32'(weight_conv_bit), 32'd1);

    // A write while streaming must be dropped (fc[2] stays 0x155).
    cfg_write(2'd3, 10'd2, 10'h0AA);

    fc_ivalid = 1; step(); fc_ivalid = 0;
    chk("fc0", 32'(weight_fc), 32'h3FF);
    step();
    chk("fc_hold_a", 32'(weight_fc), 32'h3FF);
    step();
    chk("fc_hold_b", 32'(weight_fc), 32'h3FF);
    fc_ivalid = 1; step();
    chk("fc1", 32'(weight_fc), 32'h001);
    step(); fc_ivalid = 0;
    chk("fc2_kept", 32'(weight_fc), 32'h155);

    rand_stream(1500);

    // Capture the class; a later done and a run while waiting are ignored.
    done = 1; classes_b = 4'd7; step(); done = 0;
    chk("res7", 32'(result), 32'd7);
    chk("res7_valid", 32'(result_valid), 32'd1);
    run = 1; step(); run = 0;
    chk("start_low", 32'(start), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    done = 1; classes_b = 4'd3; step(); done = 0;
    chk("res_kept", 32'(result), 32'd7);
    result_ack = 1; step(); result_ack = 0;
    chk("ack_valid", 32'(result_valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_result", 32'(result), 32'd7);

    // Reset in the middle of a stream, then restart from index 0.
    run = 1; step(); run = 0;
    rand_stream(50);
    rst = 1; step();
    chk_all_zero("midrst");
    step(); rst = 0;
    run = 1; step(); run = 0;
    step();
    chk("re_pixel0", 32'(image_bit), 32'd0);
    step();
    chk("re_pixel1", 32'(image_bit), 32'd1);
    weight_en_0 = 1; weight_en_1 = 1; step(); weight_en_0 = 0; weight_en_1 = 0;
    chk("re_conv0", 32'(weight_conv_bit), 32'd1);
    fc_ivalid = 1; step(); fc_ivalid = 0;
    chk("re_fc0", 32'(weight_fc), 32'h3FF);

    // Fully random traffic including writes, runs, dones, acks and resets.
    for (int i = 0; i < 2500; i++) begin
      rst         = ($urandom_range(199, 0) == 0);
      run         = ($urandom_range(7, 0) == 0);
      done        = ($urandom_range(39, 0) == 0);
      classes_b   = 4'($urandom_range(15, 0));
      result_ack  = ($urandom_range(5, 0) == 0);
      cfg_we      = ($urandom_range(2, 0) == 0);
      cfg_sel     = 2'($urandom_range(3, 0));
      cfg_addr    = 10'($urandom_range(1023, 0));
      cfg_wdata   = 10'($urandom_range(1023, 0));
      weight_en_0 = $urandom_range(1, 0);
      weight_en_1 = $urandom_range(1, 0);
      fc_ivalid   = $urandom_range(1, 0);
      step();
    end
    rst = 0;
    clear_in();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
